// File: rtl/lcd_timing_pkg.sv
// Shared timing definitions for the LCD timing generator: the 800x480 panel
// defaults and the per-axis timing struct consumed by lcd_axis_counter.
package lcd_timing_pkg;

    typedef struct packed {
        int active;
        int front;
        int sync;
        int back;
    } axis_timing_t;

    localparam int DEF_H_ACTIVE = 800;
    localparam int DEF_H_FRONT  = 210;
    localparam int DEF_H_SYNC   = 1;
    localparam int DEF_H_BACK   = 182;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FRONT  = 45;
    localparam int DEF_V_SYNC   = 5;
    localparam int DEF_V_BACK   = 12;

    localparam axis_timing_t DEF_H_TIMING = '{
        active: DEF_H_ACTIVE, front: DEF_H_FRONT, sync: DEF_H_SYNC, back: DEF_H_BACK};
    localparam axis_timing_t DEF_V_TIMING = '{
        active: DEF_V_ACTIVE, front: DEF_V_FRONT, sync: DEF_V_SYNC, back: DEF_V_BACK};

    function automatic int axis_total(axis_timing_t t);
        return t.active + t.front + t.sync + t.back;
    endfunction

endpackage

// File: rtl/lcd_axis_counter.sv
// One timing axis: a wrap counter (enable + carry-in, carry-out on wrap) with
// decode of the active window and the sync window.
module lcd_axis_counter
    import lcd_timing_pkg::*;
#(
    parameter axis_timing_t TIMING = DEF_H_TIMING,
    parameter int           W      = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         carry_in,
    output logic [W-1:0] cnt,
    output logic         carry_out,
    output logic         active,
    output logic         sync
);

    localparam int TOTAL   = axis_total(TIMING);
    localparam int SYNC_LO = TIMING.active + TIMING.front;
    localparam int SYNC_HI = SYNC_LO + TIMING.sync;

    // Window bounds carry one spare bit: SYNC_HI may equal TOTAL == 2**W.
    localparam logic [W-1:0] LAST       = W'(TOTAL - 1);
    localparam logic [W:0]   ACTIVE_END = (W+1)'(TIMING.active);
    localparam logic [W:0]   SYNC_START = (W+1)'(SYNC_LO);
    localparam logic [W:0]   SYNC_END   = (W+1)'(SYNC_HI);

    logic [W:0] cnt_ext;

    assign cnt_ext   = {1'b0, cnt};
    assign carry_out = carry_in && (cnt == LAST);
    assign active    = (cnt_ext < ACTIVE_END);
    assign sync      = (cnt_ext >= SYNC_START) && (cnt_ext < SYNC_END);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (en && carry_in) begin
            cnt <= carry_out ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/lcd_timing_gen.sv
// LCD panel timing generator: pixel/line counters, coordinate request, and a
// one-cycle registered panel stage. Define LCD_TIMING_GEN_MIRROR_EN for mirroring.
module lcd_timing_gen
    import lcd_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FRONT  = DEF_H_FRONT,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BACK   = DEF_H_BACK,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FRONT  = DEF_V_FRONT,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BACK   = DEF_V_BACK,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0,
    parameter int W_RED    = 5,
    parameter int W_GREEN  = 6,
    parameter int W_BLUE   = 5,
    parameter int W_X      = $clog2(H_ACTIVE),
    parameter int W_Y      = $clog2(V_ACTIVE)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pixel_en,
    input  logic               mirror_x,
    input  logic               mirror_y,
    output logic [W_X-1:0]     x,
    output logic [W_Y-1:0]     y,
    output logic               coord_valid,
    input  logic [W_RED-1:0]   red_in,
    input  logic [W_GREEN-1:0] green_in,
    input  logic [W_BLUE-1:0]  blue_in,
    output logic [W_RED-1:0]   lcd_r,
    output logic [W_GREEN-1:0] lcd_g,
    output logic [W_BLUE-1:0]  lcd_b,
    output logic               lcd_de,
    output logic               lcd_hs,
    output logic               lcd_vs,
    output logic               frame_start,
    output logic               line_start
);

    localparam axis_timing_t H_TIM = '{
        active: H_ACTIVE, front: H_FRONT, sync: H_SYNC, back: H_BACK};
    localparam axis_timing_t V_TIM = '{
        active: V_ACTIVE, front: V_FRONT, sync: V_SYNC, back: V_BACK};

    localparam int   W_H   = $clog2(axis_total(H_TIM));
    localparam int   W_V   = $clog2(axis_total(V_TIM));
    localparam logic HS_ON = (HS_POL != 0);
    localparam logic VS_ON = (VS_POL != 0);

    if (H_ACTIVE < 1 || H_SYNC < 1 || V_ACTIVE < 1 || V_SYNC < 1 ||
        H_FRONT < 0 || H_BACK < 0 || V_FRONT < 0 || V_BACK < 0) begin : g_bad_timing
        $error("lcd_timing_gen: active and sync lengths must be >= 1, porches >= 0");
    end

    logic [W_H-1:0] h_cnt;
    logic [W_V-1:0] v_cnt;
    logic           h_wrap;
    logic           h_active;
    logic           h_sync;
    logic           v_active;
    logic           v_sync;
    logic           v_wrap_unused;

    lcd_axis_counter #(.TIMING(H_TIM), .W(W_H)) u_h_counter (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (pixel_en),
        .carry_in  (1'b1),
        .cnt       (h_cnt),
        .carry_out (h_wrap),
        .active    (h_active),
        .sync      (h_sync)
    );

    lcd_axis_counter #(.TIMING(V_TIM), .W(W_V)) u_v_counter (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (pixel_en),
        .carry_in  (h_wrap),
        .cnt       (v_cnt),
        .carry_out (v_wrap_unused),
        .active    (v_active),
        .sync      (v_sync)
    );

    // Strobes are gated by rst_n so they read 0 while reset is held at the origin.
    assign coord_valid = h_active && v_active;
    assign frame_start = rst_n && pixel_en && (h_cnt == '0) && (v_cnt == '0);
    assign line_start  = rst_n && pixel_en && (h_cnt == '0) && v_active;

`ifdef LCD_TIMING_GEN_MIRROR_EN
    localparam logic [W_X-1:0] X_LAST = W_X'(H_ACTIVE - 1);
    localparam logic [W_Y-1:0] Y_LAST = W_Y'(V_ACTIVE - 1);

    logic mirror_x_q;
    logic mirror_y_q;
    logic mirror_x_eff;
    logic mirror_y_eff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mirror_x_q <= 1'b0;
            mirror_y_q <= 1'b0;
        end else if (frame_start) begin
            mirror_x_q <= mirror_x;
            mirror_y_q <= mirror_y;
        end
    end

    // Bypass the latch on the frame_start cycle so the new setting covers pixel (0,0).
    assign mirror_x_eff = frame_start ? mirror_x : mirror_x_q;
    assign mirror_y_eff = frame_start ? mirror_y : mirror_y_q;
    assign x = mirror_x_eff ? X_LAST - h_cnt[W_X-1:0] : h_cnt[W_X-1:0];
    assign y = mirror_y_eff ? Y_LAST - v_cnt[W_Y-1:0] : v_cnt[W_Y-1:0];
`else
    logic mirror_unused;

    assign mirror_unused = mirror_x ^ mirror_y;
    assign x = h_cnt[W_X-1:0];
    assign y = v_cnt[W_Y-1:0];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lcd_de <= 1'b0;
            lcd_r  <= '0;
            lcd_g  <= '0;
            lcd_b  <= '0;
            lcd_hs <= !HS_ON;
            lcd_vs <= !VS_ON;
        end else if (pixel_en) begin
            lcd_de <= coord_valid;
            lcd_r  <= coord_valid ? red_in   : '0;
            lcd_g  <= coord_valid ? green_in : '0;
            lcd_b  <= coord_valid ? blue_in  : '0;
            lcd_hs <= h_sync ? HS_ON : !HS_ON;
            lcd_vs <= v_sync ? VS_ON : !VS_ON;
        end
    end

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Randomized bench for lcd_timing_gen on a small 8x6 timing, checked against a
// frame-position reference model; mirror expectations follow LCD_TIMING_GEN_MIRROR_EN.
module tb_lcd_timing_gen;

    localparam int HA = 4, HF = 1, HS = 2, HB = 1;
    localparam int VA = 3, VF = 1, VS = 1, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FT = HT * VT;

`ifdef LCD_TIMING_GEN_MIRROR_EN
    localparam bit MIRROR_BUILD = 1'b1;
`else
    localparam bit MIRROR_BUILD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pixel_en;
    logic       mirror_x;
    logic       mirror_y;
    logic [1:0] x;
    logic [1:0] y;
    logic       coord_valid;
    logic [4:0] red_in;
    logic [5:0] green_in;
    logic [4:0] blue_in;
    logic [4:0] lcd_r;
    logic [5:0] lcd_g;
    logic [4:0] lcd_b;
    logic       lcd_de;
    logic       lcd_hs;
    logic       lcd_vs;
    logic       frame_start;
    logic       line_start;

    int checks = 0;
    int errors = 0;

    // Model state: position inside the frame in enabled pixels, plus expected registers.
    int pos;
    bit mx_q, my_q;
    bit e_de, e_hs, e_vs;
    int e_r, e_g, e_b;
    bit random_mode;
    int fs_seen, ls_seen;

    lcd_timing_gen #(
        .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .HS_POL(0), .VS_POL(0), .W_RED(5), .W_GREEN(6), .W_BLUE(5)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pixel_en(pixel_en),
        .mirror_x(mirror_x), .mirror_y(mirror_y),
        .x(x), .y(y), .coord_valid(coord_valid),
        .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
        .lcd_r(lcd_r), .lcd_g(lcd_g), .lcd_b(lcd_b),
        .lcd_de(lcd_de), .lcd_hs(lcd_hs), .lcd_vs(lcd_vs),
        .frame_start(frame_start), .line_start(line_start)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input int observed, input int expected);
        checks++;
        if (observed != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t pos=%0d)",
                     tag, observed, expected, $time, pos);
        end
    endtask

    task automatic model_reset();
        pos  = 0;
        mx_q = 1'b0;
        my_q = 1'b0;
        e_de = 1'b0;
        e_r  = 0;
        e_g  = 0;
        e_b  = 0;
        e_hs = 1'b1;
        e_vs = 1'b1;
    endtask

    task automatic check_registered();
        check_output("lcd_de", int'(lcd_de), int'(e_de));
        check_output("lcd_r",  int'(lcd_r),  e_r);
        check_output("lcd_g",  int'(lcd_g),  e_g);
        check_output("lcd_b",  int'(lcd_b),  e_b);
        check_output("lcd_hs", int'(lcd_hs), int'(e_hs));
        check_output("lcd_vs", int'(lcd_vs), int'(e_vs));
    endtask

    task automatic apply_stimulus();
        pixel_en = random_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
        red_in   = 5'($urandom);
        green_in = 6'($urandom);
        blue_in  = 5'($urandom);
        if (random_mode && $urandom_range(0, 15) == 0) mirror_x = ~mirror_x;
        if (random_mode && $urandom_range(0, 15) == 0) mirror_y = ~mirror_y;
    endtask

    task automatic run_cycle();
        int h, v, ex, ey;
        bit valid, fs, ls, mxe, mye;
        @(negedge clk);
        apply_stimulus();
        #1;
        h     = pos % HT;
        v     = pos / HT;
        valid = (h < HA) && (v < VA);
        fs    = rst_n && pixel_en && (pos == 0);
        ls    = rst_n && pixel_en && (h == 0) && (v < VA);
        mxe   = MIRROR_BUILD && (fs ? mirror_x : mx_q);
        mye   = MIRROR_BUILD && (fs ? mirror_y : my_q);
        ex    = (mxe ? (HA - 1 - h) : h) & 3;
        ey    = (mye ? (VA - 1 - v) : v) & 3;
        check_output("x",           int'(x),           ex);
        check_output("y",           int'(y),           ey);
        check_output("coord_valid", int'(coord_valid), int'(valid));
        check_output("frame_start", int'(frame_start), int'(fs));
        check_output("line_start",  int'(line_start),  int'(ls));
        fs_seen += int'(frame_start);
        ls_seen += int'(line_start);
        @(posedge clk);
        #1;
        if (!rst_n) begin
            model_reset();
        end else if (pixel_en) begin
            e_de = valid;
            e_r  = valid ? int'(red_in)   : 0;
            e_g  = valid ? int'(green_in) : 0;
            e_b  = valid ? int'(blue_in)  : 0;
            e_hs = !((h >= HA + HF) && (h < HA + HF + HS));
            e_vs = !((v >= VA + VF) && (v < VA + VF + VS));
            if (fs) begin
                mx_q = mirror_x;
                my_q = mirror_y;
            end
            pos = (pos + 1) % FT;
        end
        check_registered();
    endtask

    initial begin
        rst_n       = 1'b0;
        pixel_en    = 1'b1;
        mirror_x    = 1'b0;
        mirror_y    = 1'b0;
        red_in      = '0;
        green_in    = '0;
        blue_in     = '0;
        random_mode = 1'b0;
        model_reset();

        for (int i = 0; i < 3; i++) run_cycle();
        rst_n = 1'b1;

        // Full-rate run over one frame and a bit; mirror_x is requested mid-frame.
        fs_seen = 0;
        ls_seen = 0;
        for (int i = 0; i < FT + 12; i++) begin
            if (pos == HT + 2) mirror_x = 1'b1;
            run_cycle();
        end
        check_output("frame_start_count", fs_seen, 2);
        check_output("line_start_count",  ls_seen, 5);

        random_mode = 1'b1;
        for (int i = 0; i < 300; i++) run_cycle();

        // Drive to v=2, h=3 and pull reset between edges.
        random_mode = 1'b0;
        begin
            int steps;
            steps = (2 * HT + 3 - pos + FT) % FT;
            for (int i = 0; i < steps; i++) run_cycle();
        end
        run_cycle();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_output("async_de",  int'(lcd_de),      0);
        check_output("async_r",   int'(lcd_r),       0);
        check_output("async_hs",  int'(lcd_hs),      1);
        check_output("async_vs",  int'(lcd_vs),      1);
        check_output("async_fs",  int'(frame_start), 0);
        check_output("async_ls",  int'(line_start),  0);
        model_reset();
        for (int i = 0; i < 3; i++) run_cycle();
        rst_n = 1'b1;
        run_cycle();
        random_mode = 1'b1;
        for (int i = 0; i < 150; i++) run_cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
